// File: rtl/mips_pkg.sv
// Shared definitions for the five-stage MIPS pipeline: opcodes, control-bit
// layout and the control struct carried from decode through every stage.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_LW    = 6'h23;

    localparam int CTRL_W        = 10;
    localparam int CTRL_REGWRITE = 9;
    localparam int CTRL_MEMREAD  = 8;
    localparam int CTRL_MEMWRITE = 7;
    localparam int CTRL_MEMTOREG = 6;
    localparam int CTRL_ALUSRC   = 5;
    localparam int CTRL_REGDST   = 4;
    localparam int CTRL_BRANCH   = 3;
    localparam int CTRL_ALUOP_HI = 2;
    localparam int CTRL_ALUOP_LO = 1;
    localparam int CTRL_JUMP     = 0;

    typedef struct packed {
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       alusrc;
        logic       regdst;
        logic       branch;
        logic [1:0] aluop;
        logic       jump;
    } ctrl_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator between the load in EX and the instruction in ID.
module load_use_detect
    import mips_pkg::*;
(
    input  logic        ex_valid,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rt,
    input  logic        id_valid,
    input  logic [31:0] id_instr,
    output logic        hazard
);

    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;

    assign opcode = id_instr[31:26];
    assign rs     = id_instr[25:21];
    assign rt     = id_instr[20:16];

    // Only these opcodes read rt as a source; elsewhere rt is a destination.
    assign uses_rt = (opcode == OP_RTYPE) || (opcode == OP_BEQ) ||
                     (opcode == OP_BNE)   || (opcode == OP_SW);

    assign hazard = ex_valid && ex_memread && (ex_rt != 5'd0) && id_valid &&
                    ((ex_rt == rs) || (uses_rt && (ex_rt == rt)));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, writeback bypass
// past the register file, and branch-flush squash.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int HCNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [31:0]       id_instr,
    input  logic [31:0]       id_pc_plus4,
    input  logic [31:0]       rd1,
    input  logic [31:0]       rd2,
    input  logic [9:0]        id_ctrl,
    input  logic              wb_regwrite,
    input  logic [4:0]        wb_write_reg,
    input  logic [31:0]       wb_write_data,
    input  logic              flush,
    output logic              stall,
    output logic              ex_valid,
    output logic [9:0]        ex_ctrl,
    output logic [31:0]       ex_a,
    output logic [31:0]       ex_b,
    output logic [31:0]       ex_imm,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic [4:0]        ex_shamt,
    output logic [5:0]        ex_funct,
    output logic [31:0]       ex_pc_plus4,
    output logic [HCNT_W-1:0] hazard_count
);

    localparam logic [HCNT_W-1:0] HCNT_ONE = HCNT_W'(1);

    logic              valid_q, valid_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic [31:0]       a_q, a_d, b_q, b_d, imm_q, imm_d, pc_q, pc_d;
    logic [4:0]        rs_q, rs_d, rt_q, rt_d, rd_q, rd_d, shamt_q, shamt_d;
    logic [5:0]        funct_q, funct_d;
    logic [HCNT_W-1:0] hcnt_q, hcnt_d;
    logic              hazard;
    logic [4:0]        id_rs, id_rt;

    assign id_rs = id_instr[25:21];
    assign id_rt = id_instr[20:16];

    load_use_detect u_detect (
        .ex_valid   (valid_q),
        .ex_memread (ctrl_q.memread),
        .ex_rt      (rt_q),
        .id_valid   (id_valid),
        .id_instr   (id_instr),
        .hazard     (hazard)
    );

    // A taken branch squashes ID, so a hazard against it is moot.
    assign stall = hazard && !flush;

    always_comb begin
        a_d     = (wb_regwrite && wb_write_reg != 5'd0 && wb_write_reg == id_rs) ?
                  wb_write_data : rd1;
        b_d     = (wb_regwrite && wb_write_reg != 5'd0 && wb_write_reg == id_rt) ?
                  wb_write_data : rd2;
        imm_d   = {{16{id_instr[15]}}, id_instr[15:0]};
        rs_d    = id_rs;
        rt_d    = id_rt;
        rd_d    = id_instr[15:11];
        shamt_d = id_instr[10:6];
        funct_d = id_instr[5:0];
        pc_d    = id_pc_plus4;
        valid_d = 1'b0;
        ctrl_d  = '0;
        if (!flush && !stall && id_valid) begin
            valid_d = 1'b1;
            ctrl_d  = ctrl_t'(id_ctrl);
        end
        hcnt_d = (stall && hcnt_q != '1) ? hcnt_q + HCNT_ONE : hcnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            shamt_q <= '0;
            funct_q <= '0;
            pc_q    <= '0;
            hcnt_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            a_q     <= a_d;
            b_q     <= b_d;
            imm_q   <= imm_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            shamt_q <= shamt_d;
            funct_q <= funct_d;
            pc_q    <= pc_d;
            hcnt_q  <= hcnt_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_ctrl      = ctrl_q;
    assign ex_a         = a_q;
    assign ex_b         = b_q;
    assign ex_imm       = imm_q;
    assign ex_rs        = rs_q;
    assign ex_rt        = rt_q;
    assign ex_rd        = rd_q;
    assign ex_shamt     = shamt_q;
    assign ex_funct     = funct_q;
    assign ex_pc_plus4  = pc_q;
    assign hazard_count = hcnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: vector table through a scoreboard, then reset and
// counter-saturation sequences.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [31:0] id_instr, id_pc_plus4, rd1, rd2, wb_write_data;
    logic [9:0]  id_ctrl;
    logic        wb_regwrite;
    logic [4:0]  wb_write_reg;
    logic        flush;

    logic        stall, ex_valid;
    logic [9:0]  ex_ctrl;
    logic [31:0] ex_a, ex_b, ex_imm, ex_pc_plus4;
    logic [4:0]  ex_rs, ex_rt, ex_rd, ex_shamt;
    logic [5:0]  ex_funct;
    logic [15:0] hazard_count;

    logic        s_stall, s_ex_valid;
    logic [9:0]  s_ex_ctrl;
    logic [31:0] s_ex_a, s_ex_b, s_ex_imm, s_ex_pc_plus4;
    logic [4:0]  s_ex_rs, s_ex_rt, s_ex_rd, s_ex_shamt;
    logic [5:0]  s_ex_funct;
    logic [3:0]  s_hazard_count;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_instr(id_instr),
        .id_pc_plus4(id_pc_plus4), .rd1(rd1), .rd2(rd2), .id_ctrl(id_ctrl),
        .wb_regwrite(wb_regwrite), .wb_write_reg(wb_write_reg),
        .wb_write_data(wb_write_data), .flush(flush), .stall(stall),
        .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_a(ex_a), .ex_b(ex_b),
        .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_shamt(ex_shamt), .ex_funct(ex_funct), .ex_pc_plus4(ex_pc_plus4),
        .hazard_count(hazard_count)
    );

    id_ex_stage #(.HCNT_W(4)) dut_s (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_instr(id_instr),
        .id_pc_plus4(id_pc_plus4), .rd1(rd1), .rd2(rd2), .id_ctrl(id_ctrl),
        .wb_regwrite(wb_regwrite), .wb_write_reg(wb_write_reg),
        .wb_write_data(wb_write_data), .flush(flush), .stall(s_stall),
        .ex_valid(s_ex_valid), .ex_ctrl(s_ex_ctrl), .ex_a(s_ex_a), .ex_b(s_ex_b),
        .ex_imm(s_ex_imm), .ex_rs(s_ex_rs), .ex_rt(s_ex_rt), .ex_rd(s_ex_rd),
        .ex_shamt(s_ex_shamt), .ex_funct(s_ex_funct), .ex_pc_plus4(s_ex_pc_plus4),
        .hazard_count(s_hazard_count)
    );

    typedef struct {
        logic        vld;
        logic [31:0] instr, rd1, rd2;
        logic [9:0]  ctrl;
        logic        wbrw;
        logic [4:0]  wbreg;
        logic [31:0] wbdata;
        logic        flush;
        logic        e_stall, e_valid;
        logic [9:0]  e_ctrl;
        logic [31:0] e_a, e_b, e_imm;
    } vec_t;

    typedef struct {
        logic        valid;
        logic [9:0]  ctrl;
        logic [31:0] a, b, imm, instr, pc;
    } exp_t;

    localparam logic [31:0] LW5   = 32'h8C25_0000; // lw  $5,0($1)
    localparam logic [31:0] ADDD  = 32'h00A2_3020; // add $6,$5,$2
    localparam logic [31:0] ADDI5 = 32'h20E5_0003; // addi $5,$7,3
    localparam logic [31:0] LW0   = 32'h8C20_0000; // lw  $0,0($1)
    localparam logic [31:0] ADD00 = 32'h0000_3020; // add $6,$0,$0
    localparam logic [31:0] ADD4  = 32'h0080_1820; // add $3,$4,$0
    localparam logic [31:0] ADDIN = 32'h2001_8001; // addi $1,$0,0x8001
    localparam logic [31:0] SW5   = 32'hAC45_0000; // sw  $5,0($2)
    localparam logic [9:0]  C_LW = 10'h360, C_R = 10'h214, C_I = 10'h220, C_SW = 10'h0A0;

    vec_t vt[18];
    exp_t sb[$];
    exp_t e;
    int   n_chk = 0;
    int   n_fail = 0;
    int   exp_hcnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [9:0] c, input logic wr,
                         input logic [4:0] wreg, input logic [31:0] wdat,
                         input logic fl, input logic [31:0] pc);
        id_valid = v; id_instr = ins; rd1 = r1; rd2 = r2; id_ctrl = c;
        wb_regwrite = wr; wb_write_reg = wreg; wb_write_data = wdat;
        flush = fl; id_pc_plus4 = pc;
    endtask

    initial begin
        vt[0]  = '{1'b1, LW5,   32'h11, 32'h22, C_LW, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, C_LW, 32'h11, 32'h22, 32'h0};
        vt[1]  = '{1'b1, ADDD,  32'h55, 32'h66, C_R,  1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0, 10'h0, 32'h0, 32'h0, 32'h0};
        vt[2]  = '{1'b1, ADDD,  32'h55, 32'h66, C_R,  1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, C_R, 32'h55, 32'h66, 32'h3020};
        vt[3]  = '{1'b1, LW5,   32'h11, 32'h22, C_LW, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, C_LW, 32'h11, 32'h22, 32'h0};
        vt[4]  = '{1'b1, ADDI5, 32'h77, 32'h88, C_I,  1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, C_I, 32'h77, 32'h88, 32'h3};
        vt[5]  = '{1'b1, LW0,   32'h11, 32'h0,  C_LW, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, C_LW, 32'h11, 32'h0, 32'h0};
        vt[6]  = '{1'b1, ADD00, 32'h0,  32'h0,  C_R,  1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, C_R, 32'h0, 32'h0, 32'h3020};
        vt[7]  = '{1'b1, ADD4,  32'h33, 32'h44, C_R,  1'b1, 5'd4, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, C_R, 32'hDEADBEEF, 32'h44, 32'h1820};
        vt[8]  = '{1'b1, ADD4,  32'h33, 32'h44, C_R,  1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, C_R, 32'h33, 32'h44, 32'h1820};
        vt[9]  = '{1'b1, ADDIN, 32'h0,  32'h99, C_I,  1'b1, 5'd1, 32'hCAFEF00D, 1'b0, 1'b0, 1'b1, C_I, 32'h0, 32'hCAFEF00D, 32'hFFFF8001};
        vt[10] = '{1'b1, LW5,   32'h11, 32'h22, C_LW, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, C_LW, 32'h11, 32'h22, 32'h0};
        vt[11] = '{1'b1, ADDD,  32'h55, 32'h66, C_R,  1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0, 10'h0, 32'h0, 32'h0, 32'h0};
        vt[12] = '{1'b0, ADDD,  32'h55, 32'h66, C_R,  1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 10'h0, 32'h0, 32'h0, 32'h0};
        vt[13] = '{1'b1, ADDD,  32'h55, 32'h66, C_R,  1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, C_R, 32'h55, 32'h66, 32'h3020};
        vt[14] = '{1'b1, ADD4,  32'h33, 32'h44, C_R,  1'b0, 5'd4, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, C_R, 32'h33, 32'h44, 32'h1820};
        vt[15] = '{1'b1, LW5,   32'h11, 32'h22, C_LW, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, C_LW, 32'h11, 32'h22, 32'h0};
        vt[16] = '{1'b1, SW5,   32'hAA, 32'hBB, C_SW, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0, 10'h0, 32'h0, 32'h0, 32'h0};
        vt[17] = '{1'b1, SW5,   32'hAA, 32'hBB, C_SW, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, C_SW, 32'hAA, 32'hBB, 32'h0};

        reset = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 10'h0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset_valid", ex_valid, 0);
        chk("reset_hcnt", hazard_count, 0);

        for (int i = 0; i < 18; i++) begin
            drive(vt[i].vld, vt[i].instr, vt[i].rd1, vt[i].rd2, vt[i].ctrl, vt[i].wbrw,
                  vt[i].wbreg, vt[i].wbdata, vt[i].flush, 32'h400 + 32'(4 * i));
            sb.push_back('{vt[i].e_valid, vt[i].e_ctrl, vt[i].e_a, vt[i].e_b, vt[i].e_imm,
                           vt[i].instr, 32'h400 + 32'(4 * i)});
            #1 chk($sformatf("v%0d_stall", i), stall, vt[i].e_stall);
            if (vt[i].e_stall) exp_hcnt++;
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk($sformatf("v%0d_valid", i), ex_valid, e.valid);
            chk($sformatf("v%0d_ctrl", i), ex_ctrl, e.ctrl);
            chk($sformatf("v%0d_hcnt", i), hazard_count, exp_hcnt);
            if (e.valid) begin
                chk($sformatf("v%0d_a", i), ex_a, e.a);
                chk($sformatf("v%0d_b", i), ex_b, e.b);
                chk($sformatf("v%0d_imm", i), ex_imm, e.imm);
                chk($sformatf("v%0d_rs", i), ex_rs, e.instr[25:21]);
                chk($sformatf("v%0d_rt", i), ex_rt, e.instr[20:16]);
                chk($sformatf("v%0d_rd", i), ex_rd, e.instr[15:11]);
                chk($sformatf("v%0d_shamt", i), ex_shamt, e.instr[10:6]);
                chk($sformatf("v%0d_funct", i), ex_funct, e.instr[5:0]);
                chk($sformatf("v%0d_pc", i), ex_pc_plus4, e.pc);
            end
        end

        // Asynchronous reset in the middle of a stall cycle.
        drive(1'b1, LW5, 32'h11, 32'h22, C_LW, 1'b0, 5'd0, 32'h0, 1'b0, 32'h500);
        @(posedge clk);
        #1 drive(1'b1, ADDD, 32'h55, 32'h66, C_R, 1'b0, 5'd0, 32'h0, 1'b0, 32'h504);
        #1 chk("pre_reset_stall", stall, 1);
        chk("pre_reset_valid", ex_valid, 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_stall", stall, 0);
        chk("arst_valid", ex_valid, 0);
        chk("arst_ctrl", ex_ctrl, 0);
        chk("arst_a", ex_a, 0);
        chk("arst_b", ex_b, 0);
        chk("arst_imm", ex_imm, 0);
        chk("arst_fields", {ex_rs, ex_rt, ex_rd, ex_shamt, ex_funct}, 0);
        chk("arst_pc", ex_pc_plus4, 0);
        chk("arst_hcnt", hazard_count, 0);
        chk("arst_hcnt_s", s_hazard_count, 0);
        #1 reset = 1'b0;

        // Repeated load-use pairs drive the narrow counter into saturation.
        @(posedge clk);
        for (int k = 0; k < 20; k++) begin
            #1 drive(1'b1, LW5, 32'h11, 32'h22, C_LW, 1'b0, 5'd0, 32'h0, 1'b0, 32'h600);
            @(posedge clk);
            #1 drive(1'b1, ADDD, 32'h55, 32'h66, C_R, 1'b0, 5'd0, 32'h0, 1'b0, 32'h604);
            @(posedge clk);
        end
        #1;
        chk("sat_hcnt16", hazard_count, 20);
        chk("sat_hcnt4", s_hazard_count, 4'hF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline stage of the five-stage MIPS processor. It sits directly downstream of `register_file`: it captures the two read operands, decoder control bits and instruction fields at the end of ID and presents them registered to EX. It also does three things for this boundary: detects load-use hazards and inserts bubbles, bypasses same-cycle writeback data past the register file, and squashes on branch flush.

## Interface
Parameters:
- `HCNT_W`, 16: width of the saturating hazard-stall counter.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `id_valid`  in  1  ID holds a real instruction.
- `id_instr`  in  32  instruction word in ID.
- `id_pc_plus4`  in  32  PC+4 of the ID instruction.
- `rd1`, `rd2`  in  32 each  `Read_Data_1` and `Read_Data_2` from `register_file`, for rs and rt.
- `id_ctrl`  in  10  decoder bits `{regwrite, memread, memwrite, memtoreg, alusrc, regdst, branch, aluop[1:0], jump}`.
- `wb_regwrite`  in  1  writeback enable (same signal as `RegWrite`).
- `wb_write_reg`  in  5  writeback register number.
- `wb_write_data`  in  32  writeback data.
- `flush`  in  1  branch taken in EX; squash ID.
- `stall`  out  1  combinational; freezes PC and IF/ID.
- `ex_valid`  out  1  EX holds a real instruction.
- `ex_ctrl`  out  10  registered control bits; all zero in a bubble.
- `ex_a`, `ex_b`  out  32 each  registered rs and rt operands.
- `ex_imm`  out  32  sign-extended `instr[15:0]`.
- `ex_rs`, `ex_rt`, `ex_rd`  out  5 each  register fields.
- `ex_shamt`  out  5  shift amount field.
- `ex_funct`  out  6  function field.
- `ex_pc_plus4`  out  32  registered PC+4.
- `hazard_count`  out  `HCNT_W`  number of stall cycles.

## Operation
- Fields: rs = `instr[25:21]`, rt = `instr[20:16]`, rd = `instr[15:11]`, opcode = `instr[31:26]`.
- `uses_rt` is 1 when opcode is 0x00 (R-type), 0x04 (beq), 0x05 (bne) or 0x2B (sw).
- Load-use hazard: `ex_valid && ex_ctrl.memread && ex_rt != 0 && id_valid && (ex_rt == rs || (uses_rt && ex_rt == rt))`.
- `stall = hazard && !flush`.
- WB bypass: operand A is `wb_write_data` when `wb_regwrite && wb_write_reg != 0 && wb_write_reg == rs`; otherwise `rd1`. Operand B follows the same rule with rt and `rd2`. Register 0 is never bypassed.
- Each rising edge, highest priority first:
  - `flush`: load a bubble.
  - `stall`: load a bubble.
  - `id_valid == 0`: load a bubble.
  - otherwise load the ID instruction with `ex_valid = 1`.
- Bubble: `ex_valid = 0` and `ex_ctrl = 0`. Data fields may hold any value.
- `hazard_count` increments on every edge where `stall == 1` and saturates at all-ones.
- Flush and hazard in the same cycle: the flush wins, `stall` stays 0, and the counter does not increment.

## Timing
- Latency is 1 cycle from ID to the EX outputs.
- `stall` is combinational from the current EX state and the ID inputs, within the same cycle.
- A load-use hazard produces exactly one bubble. On the next cycle the load has left EX, so `stall` drops and the dependent instruction issues.
- The dependent instruction's loaded operand is supplied later by EX forwarding (MEM/WB). This block does not handle it.
- On `reset` assertion, asynchronously:
  - all `ex_*` outputs go to 0;
  - `ex_valid` goes to 0;
  - `hazard_count` goes to 0;
  - `stall` goes to 0, since it depends only on the now-cleared EX state.
- Reset mid-stall drops the stall immediately. A stalled ID instruction is not preserved by this block.

## Structure
- Shared package `mips_pkg`:
  - opcode constants (`OP_RTYPE`, `OP_BEQ`, `OP_BNE`, `OP_SW`, `OP_LW`);
  - control-bit index constants;
  - a `ctrl_t` packed struct used by the decoder and by every pipeline stage.
- One sub-module, `load_use_detect`, containing the hazard comparator and `uses_rt` decode. Everything else stays in `id_ex_stage`.

## Test plan
- Reset: assert `reset` mid-cycle with `ex_valid = 1` -> every output is 0 immediately, and `hazard_count = 0`.
- Load-use: `lw $5,0($1)` in EX, then `add $6,$5,$2` in ID -> `stall = 1` for exactly 1 cycle, a bubble in EX, then the `add` with `ex_rs = 5` and `hazard_count = 1`.
- No false hazard:
  - `lw $5` followed by `addi $5,$7,3` (rt is a destination) -> `stall = 0`.
  - `lw $0` followed by `add $6,$0,$0` -> `stall = 0`.
- WB bypass: `rd1 = 0x00000033`, `wb_regwrite = 1`, `wb_write_reg = 4`, `wb_write_data = 0xDEADBEEF`, ID rs = 4 -> `ex_a = 0xDEADBEEF`. With `wb_write_reg = 0` -> `ex_a = 0x00000033`.
- Flush priority: `flush = 1` together with a load-use hazard -> `stall = 0`, `ex_valid = 0`, `ex_ctrl = 0`, and `hazard_count` unchanged.
- Sign extension and saturation:
  - `instr[15:0] = 0x8001` -> `ex_imm = 0xFFFF8001`.
  - Hold a load-use hazard for 70000 cycles with `HCNT_W = 16` -> `hazard_count = 0xFFFF`.
